// File: rtl/actuation_pkg.sv
// Shared constants, FSM state type and trip-vector byte addressing for the
// actuation unit scan controller.
package actuation_pkg;

    localparam int NUM_DIV = 4;
    localparam int TRIP_W  = 8;
    localparam int FIELD_W = NUM_DIV * TRIP_W;
    localparam int VEC_W   = 3 * FIELD_W;

    localparam logic [TRIP_W-1:0] FAULT_BYTE = 8'hFF;

    localparam logic [6:0] TEMP_LSB  = 7'd64;
    localparam logic [6:0] PRESS_LSB = 7'd32;
    localparam logic [6:0] SAT_LSB   = 7'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_EVAL,
        ST_UPDATE
    } scan_state_e;

    // Division 0 sits in the most significant byte of each field.
    function automatic logic [6:0] byte_lsb(input logic [6:0] field_lsb,
                                            input logic [1:0] div);
        return field_lsb + 7'({~div, 3'b000});
    endfunction

endpackage

// File: rtl/actuation_vote.sv
// 2-of-4 coincidence voting over the assembled trip vector.
module actuation_vote
    import actuation_pkg::*;
(
    input  logic [VEC_W-1:0] trip_vec,
    output logic             vote_d0,
    output logic             vote_d1
);

    function automatic logic coincidence_2oo4(input logic [FIELD_W-1:0] field);
        logic a, b, c, d;
        a = |field[31:24];
        b = |field[23:16];
        c = |field[15:8];
        d = |field[7:0];
        return (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
    endfunction

    logic temp_vote;
    logic press_vote;
    logic sat_vote;

    assign temp_vote  = coincidence_2oo4(trip_vec[TEMP_LSB  +: FIELD_W]);
    assign press_vote = coincidence_2oo4(trip_vec[PRESS_LSB +: FIELD_W]);
    assign sat_vote   = coincidence_2oo4(trip_vec[SAT_LSB   +: FIELD_W]);

    assign vote_d0 = temp_vote | press_vote;
    assign vote_d1 = sat_vote;

endmodule

// File: rtl/actuation_scan_controller.sv
// Polls the four instrumentation divisions, votes 2-of-4 coincidence and
// holds device actuation latched until an operator reset.
module actuation_scan_controller
    import actuation_pkg::*;
#(
    parameter int SCAN_GAP = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [NUM_DIV-1:0] div_req,
    input  logic [NUM_DIV-1:0] div_ack,
    input  logic [23:0]        div_data,
    input  logic               manual_d0,
    input  logic               manual_d1,
    input  logic               reset_req,
    output logic               actuate_d0,
    output logic               actuate_d1,
    output logic [VEC_W-1:0]   trips,
    output logic [NUM_DIV-1:0] div_fault,
    output logic               scan_done
);

    localparam int GAP_W  = $clog2(SCAN_GAP + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    scan_state_e        state;
    logic [1:0]         idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               reset_pending;
    logic               vote_d0_p1;
    logic               vote_d1_p1;

    logic [VEC_W-1:0]   work_vec;
    logic [NUM_DIV-1:0] work_fault;

    logic               ack_hit;
    logic               wait_expired;
    logic               vote_d0;
    logic               vote_d1;

    assign ack_hit      = div_ack[idx];
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    actuation_vote u_vote (
        .trip_vec (work_vec),
        .vote_d0  (vote_d0),
        .vote_d1  (vote_d1)
    );

    // Working buffer: every division is overwritten (data or fault bytes) each scan.
    always_ff @(posedge clk) begin
        if (state == ST_REQ) begin
            if (ack_hit) begin
                work_vec[byte_lsb(TEMP_LSB,  idx) +: TRIP_W] <= div_data[23:16];
                work_vec[byte_lsb(PRESS_LSB, idx) +: TRIP_W] <= div_data[15:8];
                work_vec[byte_lsb(SAT_LSB,   idx) +: TRIP_W] <= div_data[7:0];
                work_fault[idx] <= 1'b0;
            end else if (wait_expired) begin
                work_vec[byte_lsb(TEMP_LSB,  idx) +: TRIP_W] <= FAULT_BYTE;
                work_vec[byte_lsb(PRESS_LSB, idx) +: TRIP_W] <= FAULT_BYTE;
                work_vec[byte_lsb(SAT_LSB,   idx) +: TRIP_W] <= FAULT_BYTE;
                work_fault[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= 2'd0;
            gap_cnt       <= '0;
            wait_cnt      <= '0;
            reset_pending <= 1'b0;
            vote_d0_p1    <= 1'b0;
            vote_d1_p1    <= 1'b0;
            div_req       <= '0;
            actuate_d0    <= 1'b0;
            actuate_d1    <= 1'b0;
            trips         <= '0;
            div_fault     <= '0;
            scan_done     <= 1'b0;
        end else begin
            scan_done <= 1'b0;

            // A request arriving during UPDATE survives into the next scan.
            if (state == ST_UPDATE) begin
                reset_pending <= reset_req;
            end else if (reset_req) begin
                reset_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (gap_cnt == GAP_W'(SCAN_GAP - 1)) begin
                        state    <= ST_REQ;
                        idx      <= 2'd0;
                        wait_cnt <= '0;
                        div_req  <= 4'b0001;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_REQ: begin
                    if (ack_hit || wait_expired) begin
                        if (idx == 2'd3) begin
                            state   <= ST_EVAL;
                            div_req <= '0;
                        end else begin
                            idx      <= idx + 2'd1;
                            div_req  <= div_req << 1;
                            wait_cnt <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_EVAL: begin
                    vote_d0_p1 <= vote_d0;
                    vote_d1_p1 <= vote_d1;
                    state      <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    actuate_d0 <= vote_d0_p1 | manual_d0 | (actuate_d0 & ~reset_pending);
                    actuate_d1 <= vote_d1_p1 | manual_d1 | (actuate_d1 & ~reset_pending);
                    trips      <= work_vec;
                    div_fault  <= work_fault;
                    scan_done  <= 1'b1;
                    gap_cnt    <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_actuation_scan_controller.sv
// Directed bench for actuation_scan_controller with a behavioural division responder.
module tb_actuation_scan_controller;

    localparam int SCAN_GAP = 16;
    localparam int TIMEOUT  = 64;
    localparam int BUDGET   = 400;

    logic        clk;
    logic        rst_n;
    logic [3:0]  div_req;
    logic [3:0]  div_ack;
    logic [23:0] div_data;
    logic        manual_d0;
    logic        manual_d1;
    logic        reset_req;
    logic        actuate_d0;
    logic        actuate_d1;
    logic [95:0] trips;
    logic [3:0]  div_fault;
    logic        scan_done;

    int n_cmp = 0;
    int n_err = 0;

    // mode: 0 = ack in first cycle, 1 = never ack, 2 = ack on the timeout edge
    int          mode[4];
    logic [23:0] vals[4];
    int          req_cyc[4];
    int          req_len[4];

    actuation_scan_controller #(
        .SCAN_GAP (SCAN_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_req    (div_req),
        .div_ack    (div_ack),
        .div_data   (div_data),
        .manual_d0  (manual_d0),
        .manual_d1  (manual_d1),
        .reset_req  (reset_req),
        .actuate_d0 (actuate_d0),
        .actuate_d1 (actuate_d1),
        .trips      (trips),
        .div_fault  (div_fault),
        .scan_done  (scan_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!scan_done && cyc < BUDGET);
        chk({tag, "_done_seen"}, 96'(scan_done), 96'd1);
        chk({tag, "_cycles"}, 96'(cyc), 96'(exp_cyc));
    endtask

    task automatic pulse_reset_req();
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
    endtask

    // Division responder: reacts on the falling edge to the registered request.
    initial begin
        logic [3:0]  ack;
        logic [23:0] data;
        div_ack  = '0;
        div_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_cyc[i] = 0;
            req_len[i] = 0;
        end
        forever begin
            @(negedge clk);
            ack  = '0;
            data = '0;
            for (int i = 0; i < 4; i++) begin
                if (div_req[i]) begin
                    req_cyc[i]++;
                end else begin
                    if (req_cyc[i] != 0) req_len[i] = req_cyc[i];
                    req_cyc[i] = 0;
                end
                if (div_req[i] && (mode[i] == 0 || (mode[i] == 2 && req_cyc[i] == TIMEOUT))) begin
                    ack[i] = 1'b1;
                    data   = vals[i];
                end
            end
            div_ack  = ack;
            div_data = data;
        end
    end

    initial begin
        bit found;
        rst_n     = 1'b0;
        manual_d0 = 1'b0;
        manual_d1 = 1'b0;
        reset_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode[i] = 0;
            vals[i] = 24'h0;
        end
        vals[0] = 24'h010000;
        vals[1] = 24'h010000;

        repeat (3) @(negedge clk);
        chk("rst_div_req",   96'(div_req),    96'd0);
        chk("rst_act_d0",    96'(actuate_d0), 96'd0);
        chk("rst_act_d1",    96'(actuate_d1), 96'd0);
        chk("rst_trips",     trips,           96'd0);
        chk("rst_div_fault", 96'(div_fault),  96'd0);
        chk("rst_scan_done", 96'(scan_done),  96'd0);
        rst_n = 1'b1;

        // Two temperature trips, all divisions immediate
        wait_done("t1", SCAN_GAP + 6);
        chk("t1_trips", trips, 96'h01010000_00000000_00000000);
        chk("t1_act_d0", 96'(actuate_d0), 96'd1);
        chk("t1_act_d1", 96'(actuate_d1), 96'd0);
        chk("t1_fault",  96'(div_fault),  96'd0);
        chk("t1_req3_len", 96'(req_len[3]), 96'd1);
        @(negedge clk);
        chk("t1_done_pulse", 96'(scan_done), 96'd0);

        // Single saturation trip; D0 stays latched with its trip gone
        vals[0] = 24'h0;
        vals[1] = 24'h0;
        vals[2] = 24'h000005;
        wait_done("t2", SCAN_GAP + 5);
        chk("t2_trips", trips, 96'h00000000_00000000_00000500);
        chk("t2_act_d0", 96'(actuate_d0), 96'd1);
        chk("t2_act_d1", 96'(actuate_d1), 96'd0);

        // Second saturation trip completes the coincidence
        vals[3] = 24'h000040;
        wait_done("t3", SCAN_GAP + 6);
        chk("t3_trips", trips, 96'h00000000_00000000_00000540);
        chk("t3_act_d1", 96'(actuate_d1), 96'd1);
        chk("t3_act_d0", 96'(actuate_d0), 96'd1);

        // Operator reset with no trips clears both latches
        vals[2] = 24'h0;
        vals[3] = 24'h0;
        pulse_reset_req();
        wait_done("t4", SCAN_GAP + 5);
        chk("t4_act_d0", 96'(actuate_d0), 96'd0);
        chk("t4_act_d1", 96'(actuate_d1), 96'd0);
        chk("t4_trips", trips, 96'd0);

        // Pressure coincidence; reset while still voting keeps D0
        vals[0] = 24'h008000;
        vals[1] = 24'h008000;
        wait_done("t5a", SCAN_GAP + 6);
        chk("t5a_trips", trips, 96'h00000000_80800000_00000000);
        chk("t5a_act_d0", 96'(actuate_d0), 96'd1);
        pulse_reset_req();
        wait_done("t5b", SCAN_GAP + 5);
        chk("t5b_act_d0", 96'(actuate_d0), 96'd1);

        // Reset request landing in the UPDATE cycle applies one scan later
        vals[0] = 24'h0;
        vals[1] = 24'h0;
        repeat (SCAN_GAP + 5) @(negedge clk);
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        chk("t6_done", 96'(scan_done), 96'd1);
        chk("t6_act_d0", 96'(actuate_d0), 96'd1);
        chk("t6_trips", trips, 96'd0);
        wait_done("t7", SCAN_GAP + 6);
        chk("t7_act_d0", 96'(actuate_d0), 96'd0);

        // Manual D1; division 0 acks on the same edge its timeout would fire
        manual_d1 = 1'b1;
        mode[0]   = 2;
        vals[0]   = 24'h000011;
        wait_done("t8", SCAN_GAP + TIMEOUT + 5);
        chk("t8_trips", trips, 96'h00000000_00000000_11000000);
        chk("t8_fault", 96'(div_fault), 96'd0);
        chk("t8_act_d1", 96'(actuate_d1), 96'd1);
        chk("t8_act_d0", 96'(actuate_d0), 96'd0);
        chk("t8_req0_len", 96'(req_len[0]), 96'(TIMEOUT));
        manual_d1 = 1'b0;
        mode[0]   = 0;
        vals[0]   = 24'h0;

        // Division 1 silent: faulted, its bytes forced to FF, votes with division 3
        mode[1] = 1;
        vals[3] = 24'h010101;
        pulse_reset_req();
        wait_done("t9", SCAN_GAP + TIMEOUT + 4);
        chk("t9_trips", trips, 96'h00FF0001_00FF0001_00FF0001);
        chk("t9_fault", 96'(div_fault), 96'b0010);
        chk("t9_act_d0", 96'(actuate_d0), 96'd1);
        chk("t9_act_d1", 96'(actuate_d1), 96'd1);
        chk("t9_req1_len", 96'(req_len[1]), 96'(TIMEOUT));

        // Asynchronous reset in the middle of REQ(2)
        mode[1] = 0;
        for (int i = 0; i < 4; i++) vals[i] = 24'h000001;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (div_req[2]) found = 1'b1;
        end
        chk("t10_req2_seen", 96'(found), 96'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t10_div_req", 96'(div_req),    96'd0);
        chk("t10_act_d0",  96'(actuate_d0), 96'd0);
        chk("t10_act_d1",  96'(actuate_d1), 96'd0);
        chk("t10_trips",   trips,           96'd0);
        chk("t10_fault",   96'(div_fault),  96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("t11", SCAN_GAP + 6);
        chk("t11_trips", trips, 96'h00000000_00000000_01010101);
        chk("t11_act_d0", 96'(actuate_d0), 96'd0);
        chk("t11_act_d1", 96'(actuate_d1), 96'd1);
        chk("t11_fault", 96'(div_fault), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
